cpu_multicycle_sequencer: RTL and testbench
===========================================

Name: cpu_multicycle_sequencer

Overview:
- Multicycle control FSM for the MIPS datapath. It fetches into an instruction register (ir) that drives the combinational instruction decoder.
- It consumes the decoder's 32-bit control word and sequences FETCH/DECODE/EXECUTE/MEM/WB.
- It handshakes with instruction memory, data memory and the multicycle multiplier.
- It gates the register-file write to one cycle per instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- PC_STEP, 4, PC increment per fetch.
- TIMEOUT, 255, maximum wait cycles on any ready/done handshake before fault (8-bit counter, 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_rdata  in  32  fetched instruction.
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- ir  out  32  instruction register, feeds the decoder.
- ctrl_word  in  32  decoder output. Bit layout: [22] wr_regfile, [21:17] rs, [16:12] rt, [11:7] rd, [6] mux_alu, [5:3] alu_control, [2] cs, [1] wr, [0] mux_reg.
- dmem_cs  out  1  data memory select.
- dmem_wr  out  1  data memory write (valid only with dmem_cs).
- dmem_ready  in  1  data access complete.
- alu_start  out  1  one-cycle multiply launch pulse.
- alu_done  in  1  multiply result valid.
- rf_we  out  1  register-file write strobe.
- pc  out  32  program counter.
- halted  out  1  FSM in HALT.
- err  out  1  sticky handshake-timeout fault.
- retired_cnt  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, pc=RESET_PC, ir=0.
  - imem_req, dmem_cs, dmem_wr, alu_start, rf_we, halted, err = 0.
  - wait counter = 0, retired_cnt = 0.
  - Any outstanding memory/ALU transaction is abandoned with no completion.
- Opcode is ir[31:26]: 1=R-type, 2=load, 3=store, 6'h3F=halt. Any other opcode is a NOP.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_ready=1 (the same-cycle ready counts as zero-wait): ir<=imem_rdata, pc<=pc+PC_STEP (wraps modulo 2^32), -> DECODE.
- DECODE (1 cycle; ctrl_word valid):
  - halt -> HALT.
  - NOP -> FETCH; counts as retired.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - If alu_control==4 (mul): alu_start=1 on the first EXECUTE cycle only. Stay until alu_done=1; alu_done is sampled from the alu_start cycle onward.
  - Non-mul: single cycle.
  - Exit: ctrl_word[2]=1 -> MEM, else -> WB.
- MEM:
  - dmem_cs=1 and dmem_wr=ctrl_word[1], held until dmem_ready=1.
  - Then: store -> FETCH (retired); load -> WB.
- WB: rf_we=ctrl_word[22] for exactly one cycle, retire, -> FETCH.
- HALT: absorbing; halted=1; only rst_n exits.
- Timeout:
  - The wait counter clears on entry to FETCH, EXECUTE and MEM.
  - It increments each cycle the awaited ready/done is low.
  - On reaching TIMEOUT: err<=1, all strobes drop next cycle, -> HALT.
- The ready/done inputs are ignored outside their own wait state.

Optional Feature:
- SEQ_PERF_CNT_EN defined: retired_cnt increments by 1 on each retire event (NOP, store completion, WB cycle) and wraps at 2^32. Halt is not counted.
- Undefined: retired_cnt tied to 0, no counter flops; all other behaviour identical.

Decomposition:
- Package cpu_ctrl_pkg:
  - State enum: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT.
  - Opcode constants: OP_RTYPE=1, OP_LOAD=2, OP_STORE=3, OP_HALT=6'h3F.
  - ALU_MUL=3'd4.
  - Control-word bit index/field constants (CW_WR_REGFILE=22, CW_ALU_HI=5, CW_ALU_LO=3, CW_CS=2, CW_WR=1).
- One sub-module, seq_wait_timer: clear/enable/expired counter parameterised by TIMEOUT.

Test Plan:
- Reset check: drive rst_n=0 mid-MEM with dmem_cs=1. Required: dmem_cs=0 immediately (async). After release: pc=0, state IDLE, all strobes 0, err=0.
- R-type add, zero-wait memory:
  - Stimulus: start=1; imem returns 32'h0422_1020 (op=1, rs=1, rt=2, rd=2, funct=0x20) with ready in the request cycle.
  - Required: FETCH, DECODE, EXECUTE, WB on consecutive cycles; rf_we=1 exactly one cycle (cycle 4); pc=4; no dmem_cs.
- Load with slow memory:
  - Stimulus: ir=32'h0841_0000 (op=2); dmem_ready asserted on the 4th MEM cycle.
  - Required: dmem_cs=1 and dmem_wr=0 for 4 cycles, then one rf_we pulse.
- Store:
  - Stimulus: ir=32'h0C41_0000 (op=3).
  - Required: dmem_cs=1 and dmem_wr=1 until ready; rf_we never asserted; next cycle is FETCH with pc+4.
- Multiply:
  - Stimulus: funct=50; alu_done arrives 5 cycles after alu_start.
  - Required: alu_start high exactly 1 cycle, EXECUTE held 6 cycles, then WB rf_we.
- Fault and halt:
  - With TIMEOUT=8, hold imem_ready=0. Required: err=1 and halted=1 after 8 wait cycles; start ignored.
  - Separately, fetch 32'hFC00_0000. Required: halted=1 after DECODE, pc frozen.
  - With SEQ_PERF_CNT_EN, 3 instructions + halt. Required: retired_cnt=3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd1;
  localparam logic [5:0] OP_LOAD  = 6'd2;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [2:0] ALU_MUL = 3'd4;

  localparam int CW_WR_REGFILE = 22;
  localparam int CW_ALU_HI     = 5;
  localparam int CW_ALU_LO     = 3;
  localparam int CW_CS         = 2;
  localparam int CW_WR         = 1;

  // Anything outside the decoded opcode set retires without touching the datapath.
  function automatic logic is_nop(input logic [5:0] op);
    return !(op == OP_RTYPE || op == OP_LOAD || op == OP_STORE || op == OP_HALT);
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Handshake wait counter: clears on state entry, counts stalled cycles,
// flags expiry combinationally on the TIMEOUT-th stalled cycle.
module seq_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB control FSM with handshake timeout.
// SEQ_PERF_CNT_EN adds the retired-instruction counter; otherwise retired_cnt is 0.
module cpu_multicycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ir,
  input  logic [31:0] ctrl_word,
  output logic        dmem_cs,
  output logic        dmem_wr,
  input  logic        dmem_ready,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        halted,
  output logic        err,
  output logic [31:0] retired_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        err_q, err_d;
  logic        first_q, first_d;
  logic        wait_en;
  logic        retire;
  logic        expired;
  logic [5:0]  opcode;
  logic        is_mul;
  logic        ctrl_unused;

  assign opcode      = ir_q[31:26];
  assign is_mul      = (ctrl_word[CW_ALU_HI:CW_ALU_LO] == ALU_MUL);
  assign ctrl_unused = &{1'b0, ctrl_word[31:23], ctrl_word[21:6], ctrl_word[0]};

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign err       = err_q;
  assign halted    = (state_q == HALT);

  seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_d != state_q),
    .en_i      (wait_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    err_d     = err_q;
    first_d   = 1'b0;
    wait_en   = 1'b0;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_cs   = 1'b0;
    dmem_wr   = 1'b0;
    alu_start = 1'b0;
    rf_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_STEP;
          state_d = DECODE;
        end else begin
          wait_en = 1'b1;
        end
      end
      DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = HALT;
        end else if (is_nop(opcode)) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          first_d = 1'b1;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        // Multiply launches once and may complete in its own launch cycle.
        if (is_mul && !alu_done) begin
          alu_start = first_q;
          wait_en   = 1'b1;
        end else begin
          alu_start = is_mul && first_q;
          state_d   = ctrl_word[CW_CS] ? MEM : WB;
        end
      end
      MEM: begin
        dmem_cs = 1'b1;
        dmem_wr = ctrl_word[CW_WR];
        if (dmem_ready) begin
          if (ctrl_word[CW_WR]) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else begin
          wait_en = 1'b1;
        end
      end
      WB: begin
        rf_we   = ctrl_word[CW_WR_REGFILE];
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (expired) begin
      err_d   = 1'b1;
      state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  logic retire_unused;
  assign retire_unused = retire;
  assign retired_cnt   = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Randomised and directed bench for cpu_multicycle_sequencer against a per-instruction cycle-script model.
module tb_cpu_multicycle_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ir;
  logic [31:0] ctrl_word;
  logic        dmem_cs;
  logic        dmem_wr;
  logic        dmem_ready;
  logic        alu_start;
  logic        alu_done;
  logic        rf_we;
  logic [31:0] pc;
  logic        halted;
  logic        err;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  cpu_multicycle_sequencer #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .ir          (ir),
    .ctrl_word   (ctrl_word),
    .dmem_cs     (dmem_cs),
    .dmem_wr     (dmem_wr),
    .dmem_ready  (dmem_ready),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .rf_we       (rf_we),
    .pc          (pc),
    .halted      (halted),
    .err         (err),
    .retired_cnt (retired_cnt)
  );

  // Stand-in for the combinational instruction decoder.
  always_comb begin
    ctrl_word = '0;
    case (ir[31:26])
      6'd1: begin
        ctrl_word[22]    = 1'b1;
        ctrl_word[21:17] = ir[25:21];
        ctrl_word[16:12] = ir[20:16];
        ctrl_word[11:7]  = ir[15:11];
        ctrl_word[5:3]   = (ir[5:0] == 6'd50) ? 3'd4 : 3'd2;
      end
      6'd2: begin
        ctrl_word[22]    = 1'b1;
        ctrl_word[21:17] = ir[25:21];
        ctrl_word[11:7]  = ir[20:16];
        ctrl_word[6]     = 1'b1;
        ctrl_word[5:3]   = 3'd2;
        ctrl_word[2]     = 1'b1;
        ctrl_word[0]     = 1'b1;
      end
      6'd3: begin
        ctrl_word[21:17] = ir[25:21];
        ctrl_word[16:12] = ir[20:16];
        ctrl_word[6]     = 1'b1;
        ctrl_word[5:3]   = 3'd2;
        ctrl_word[2]     = 1'b1;
        ctrl_word[1]     = 1'b1;
      end
      default: ;
    endcase
  end

  // ph: 0 other, 1 fetch wait, 2 mul wait, 3 mem wait, 4 decode.
  // exp: {imem_req, dmem_cs, dmem_wr, alu_start, rf_we, halted, err}
  typedef struct packed {
    logic [2:0] ph;
    logic       imr;
    logic       dmr;
    logic       ald;
    logic [6:0] exp;
  } step_t;

  step_t       q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] pc_m;
  int          ret_m;

  function automatic logic [31:0] obs();
    return {25'd0, imem_req, dmem_cs, dmem_wr, alu_start, rf_we, halted, err};
  endfunction

  function automatic step_t mk(input logic [2:0] ph, input logic imr, input logic dmr,
                               input logic ald, input logic [6:0] exp);
    step_t s;
    s.ph = ph; s.imr = imr; s.dmr = dmr; s.ald = ald; s.exp = exp;
    return s;
  endfunction

  function automatic logic [31:0] ret_exp();
`ifdef SEQ_PERF_CNT_EN
    return 32'(ret_m);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; alu_done = 1'b0; imem_rdata = '0;
    #1 chk("rst_strobes_async", obs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pc_m = 32'h0; ret_m = 0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_retired", retired_cnt, 32'd0);
    @(negedge clk);
    chk("idle_strobes", obs(), 32'd0);
    start = 1'b1;
  endtask

  // Expected cycle script for one instruction, derived from the opcode and the chosen latencies.
  task automatic run_instr(input logic [31:0] instr, input int fl, input int ml, input int al);
    logic [5:0] op;
    logic       mul;
    step_t      s;
    op  = instr[31:26];
    mul = (op == 6'd1) && (instr[5:0] == 6'd50);
    q.delete();
    for (int k = 0; k <= fl; k++) q.push_back(mk(3'd1, k == fl, 1'b0, 1'b0, 7'b1000000));
    q.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 7'b0));
    if (op == 6'd1 || op == 6'd2 || op == 6'd3) begin
      if (mul) begin
        for (int k = 0; k <= al; k++)
          q.push_back(mk(3'd2, 1'b0, 1'b0, k == al, (k == 0) ? 7'b0001000 : 7'b0));
      end else begin
        q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 7'b0));
      end
      if (op != 6'd1) begin
        for (int k = 0; k <= ml; k++)
          q.push_back(mk(3'd3, 1'b0, k == ml, 1'b0, {1'b0, 1'b1, op == 6'd3, 4'b0}));
      end
      if (op != 6'd3) q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 7'b0000100));
    end
    for (int i = 0; i < q.size(); i++) begin
      s = q[i];
      @(negedge clk);
      chk("strobes", obs(), 32'(s.exp));
      if (s.ph == 3'd1) chk("imem_addr", imem_addr, pc_m);
      if (s.ph == 3'd4) begin
        chk("ir", ir, instr);
        chk("retired", retired_cnt, ret_exp());
      end
      start      = 1'($urandom);
      imem_ready = (s.ph == 3'd1) ? s.imr : 1'($urandom);
      imem_rdata = (s.ph == 3'd1) ? instr : $urandom;
      dmem_ready = (s.ph == 3'd3) ? s.dmr : 1'($urandom);
      alu_done   = (s.ph == 3'd2) ? s.ald : 1'($urandom);
    end
    pc_m = pc_m + 32'd4;
    ret_m++;
    chk("pc", pc, pc_m);
  endtask

  task automatic run_halt(input int fl);
    for (int k = 0; k <= fl; k++) begin
      @(negedge clk);
      chk("halt_fetch", obs(), 32'b1000000);
      imem_ready = (k == fl); imem_rdata = 32'hFC00_0000;
    end
    @(negedge clk);
    chk("halt_decode", obs(), 32'd0);
    imem_ready = 1'b0;
    pc_m = pc_m + 32'd4;
    repeat (4) begin
      @(negedge clk);
      chk("halted", obs(), 32'b0000010);
      chk("halt_pc", pc, pc_m);
      chk("halt_retired", retired_cnt, ret_exp());
      start = 1'b1; imem_ready = 1'($urandom); dmem_ready = 1'($urandom); alu_done = 1'($urandom);
    end
  endtask

  initial begin
    logic [31:0] instr;
    int          kind;

    do_reset();
    run_instr(32'h0422_1020, 0, 0, 0);
    run_instr(32'h0841_0000, 0, 3, 0);
    run_instr(32'h0C41_0000, 2, 2, 0);
    run_instr(32'h0422_1032, 1, 0, 5);
    run_instr(32'h0000_0000, 0, 0, 0);
    for (int n = 0; n < 30; n++) begin
      kind  = $urandom_range(0, 4);
      instr = $urandom;
      case (kind)
        0: instr = {6'd1, instr[25:6], 6'h20};
        1: instr = {6'd1, instr[25:6], 6'd50};
        2: instr[31:26] = 6'd2;
        3: instr[31:26] = 6'd3;
        default: instr[31:26] = 6'($urandom_range(4, 62));
      endcase
      run_instr(instr, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 6));
    end
    run_halt(1);

    // Three retiring instructions then halt from a fresh reset.
    do_reset();
    run_instr(32'h0422_1020, 0, 0, 0);
    run_instr(32'h0C41_0000, 0, 1, 0);
    run_instr(32'h1000_0000, 0, 0, 0);
    run_halt(0);

    // Reset abandons a load stalled in MEM.
    do_reset();
    @(negedge clk);
    chk("mid_fetch", obs(), 32'b1000000);
    start = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0841_0000;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem", obs(), 32'b0100000);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_dmem_cs", 32'(dmem_cs), 32'd0);
    do_reset();

    // Fetch that never completes hits the timeout.
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_wait", obs(), 32'b1000000);
      start = 1'b0; imem_ready = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk("to_fault", obs(), 32'b0000011);
      chk("to_pc", pc, 32'h0);
      start = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
